// File: rtl/activation_packer_if.sv
// Valid/ready stream bundle used on both sides of the activation packer.
// The master drives data and valid; the slave answers with ready.
interface activation_packer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/activation_packer.sv
// Packs LANES consecutive BITWIDTH-bit activations from the a stream into one
// x word (first activation in lane 0). A flush pulse closes a partial word,
// zero-padding the unused upper lanes. If the output register is still busy,
// the padded word waits in DRAIN until the register is free.
module activation_packer #(
  parameter int BITWIDTH = 4,
  parameter int LANES    = 3
) (
  input  logic                 CLK,
  input  logic                 RST,     // synchronous, active-low
  activation_packer_if.slave   a,       // BITWIDTH-wide activations in
  activation_packer_if.master  x,       // LANES*BITWIDTH-wide words out
  input  logic                 flush,
  output logic [1:0]           status
);

  localparam int WORD_W = LANES * BITWIDTH;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] xdata_q, xdata_d;
  logic              xvalid_q, xvalid_d;
  logic [WORD_W-1:0] pad_q, pad_d;

  logic              out_free;
  logic              a_ready;
  logic              beat;
  logic              last_beat;
  logic [CNT_W:0]    fill_n;
  logic [WORD_W-1:0] merged_word;
  logic [WORD_W-1:0] padded_word;

  // The output register can take a new word when empty or being sent now.
  assign out_free  = !xvalid_q || x.tready;
  // Only the beat that completes a word needs the output register free.
  assign a_ready   = RST && (state_q == FILL) && ((cnt_q != LAST) || out_free);
  assign beat      = a.tvalid && a_ready;
  assign last_beat = beat && (cnt_q == LAST);
  // Number of lanes holding data once this cycle's beat is counted.
  assign fill_n    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, beat};

  // Lane gi of the accumulator with this cycle's beat merged in, and the
  // same lane with everything at or above fill_n forced to zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged_word[gi*BITWIDTH +: BITWIDTH] =
      (beat && (cnt_q == CNT_W'(gi))) ? a.tdata : acc_q[gi*BITWIDTH +: BITWIDTH];
    assign padded_word[gi*BITWIDTH +: BITWIDTH] =
      ((CNT_W+1)'(gi) < fill_n) ? merged_word[gi*BITWIDTH +: BITWIDTH] : '0;
  end

  assign a.tready = a_ready;
  assign x.tdata  = xdata_q;
  assign x.tvalid = xvalid_q;
  assign status   = {state_q == DRAIN, cnt_q != '0};

  // Next-state: accumulate beats, emit full/padded words, handle DRAIN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    xdata_d  = xdata_q;
    xvalid_d = xvalid_q;
    pad_d    = pad_q;

    // A word leaving (or an already empty register) clears valid unless
    // something below loads a fresh word.
    if (out_free) begin
      xvalid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (last_beat) begin
          xdata_d  = merged_word;
          xvalid_d = 1'b1;
          cnt_d    = '0;
        end else if (beat) begin
          acc_d = merged_word;
          cnt_d = cnt_q + 1'b1;
        end

        // A full word already consumed the flush; empty flushes do nothing.
        if (flush && (fill_n != '0) && !last_beat) begin
          if (out_free) begin
            xdata_d  = padded_word;
            xvalid_d = 1'b1;
            cnt_d    = '0;
          end else begin
            pad_d   = padded_word;
            cnt_d   = fill_n[CNT_W-1:0];
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (out_free) begin
          xdata_d  = pad_q;
          xvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  // State registers; reset discards any pending lanes and held words.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      acc_q    <= '0;
      xdata_q  <= '0;
      xvalid_q <= 1'b0;
      pad_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      xdata_q  <= xdata_d;
      xvalid_q <= xvalid_d;
      pad_q    <= pad_d;
    end
  end

endmodule
